// File: rtl/kvadd2_example_ar_issuer.sv
// rtl/kvadd2_example_ar_issuer.sv - AXI4 AR burst issuer with outstanding-burst cap
// Optional feature macro: KVADD2_AR_ISSUER_STATS_EN (adds stat_stall_cycles output).
module kvadd2_example_ar_issuer #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BURST_LEN       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         ctrl_done,
`ifdef KVADD2_AR_ISSUER_STATS_EN
  output logic [31:0]                  stat_stall_cycles,
`endif
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  input  logic                         rxfer_last
);

  localparam int BPB         = C_DATA_WIDTH / 8;
  localparam int LOG_BPB     = $clog2(BPB);
  localparam int LOG_BL      = $clog2(C_BURST_LEN);
  localparam int BURST_BYTES = C_BURST_LEN * BPB;
  // One spare bit so the round-up additions cannot overflow.
  localparam int SW          = C_XFER_SIZE_WIDTH + 1;

  localparam logic [C_ADDR_WIDTH-1:0] BURST_STEP = C_ADDR_WIDTH'(BURST_BYTES);
  localparam logic [C_ADDR_WIDTH-1:0] ALIGN_MASK = ~(C_ADDR_WIDTH'(BURST_BYTES - 1));
  localparam logic [7:0]              FULL_ARLEN = 8'(C_BURST_LEN - 1);
  localparam logic [7:0]              MAX_OUT    = 8'(C_MAX_OUTSTANDING);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, DONE} state_t;

  state_t        state;
  logic [SW-1:0] size_r;
  logic [SW-1:0] beats;
  logic [SW-1:0] bursts;
  logic [SW-1:0] bursts_rem;
  logic [7:0]    last_arlen;
  logic [7:0]    last_arlen_r;
  logic [7:0]    outstanding;
  logic [7:0]    outstanding_nxt;
  logic          ar_hs;

  // Split the latched byte count into beats, bursts and the tail burst length.
  always_comb begin
    beats      = (size_r + SW'(BPB - 1)) >> LOG_BPB;
    bursts     = (beats + SW'(C_BURST_LEN - 1)) >> LOG_BL;
    last_arlen = 8'(beats - ((bursts - SW'(1)) << LOG_BL) - SW'(1));
  end

  // Outstanding-burst up/down count; a stray retire at zero is dropped.
  always_comb begin
    ar_hs           = m_axi_arvalid & m_axi_arready;
    outstanding_nxt = outstanding;
    if (ar_hs && !rxfer_last) begin
      outstanding_nxt = outstanding + 8'd1;
    end else if (!ar_hs && rxfer_last && outstanding != 8'd0) begin
      outstanding_nxt = outstanding - 8'd1;
    end
  end

  // Control FSM with registered AR channel and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ctrl_done     <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= 8'd0;
      outstanding   <= 8'd0;
      size_r        <= '0;
      bursts_rem    <= '0;
      last_arlen_r  <= 8'd0;
    end else begin
      outstanding <= outstanding_nxt;
      ctrl_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_start) begin
            m_axi_araddr <= ctrl_addr_offset & ALIGN_MASK;
            size_r       <= {1'b0, ctrl_xfer_size_in_bytes};
            state        <= CALC;
          end
        end
        CALC: begin
          bursts_rem   <= bursts;
          last_arlen_r <= last_arlen;
          m_axi_arlen  <= (bursts == SW'(1)) ? last_arlen : FULL_ARLEN;
          if (beats == '0) begin
            ctrl_done <= 1'b1;
            state     <= DONE;
          end else begin
            m_axi_arvalid <= (outstanding_nxt < MAX_OUT);
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (ar_hs) begin
            m_axi_araddr <= m_axi_araddr + BURST_STEP;
            bursts_rem   <= bursts_rem - SW'(1);
            m_axi_arlen  <= (bursts_rem == SW'(2)) ? last_arlen_r : FULL_ARLEN;
            if (bursts_rem == SW'(1)) begin
              m_axi_arvalid <= 1'b0;
              state         <= DRAIN;
            end else begin
              m_axi_arvalid <= (outstanding_nxt < MAX_OUT);
            end
          end else if (!m_axi_arvalid) begin
            // Limit only gates new assertions; a pending request is held.
            m_axi_arvalid <= (outstanding_nxt < MAX_OUT);
          end
        end
        DRAIN: begin
          if (outstanding == 8'd0) begin
            ctrl_done <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef KVADD2_AR_ISSUER_STATS_EN
  // Count ISSUE cycles where the outstanding cap holds arvalid low.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_cycles <= 32'd0;
    end else if (state == IDLE && ctrl_start) begin
      stat_stall_cycles <= 32'd0;
    end else if (state == ISSUE && !m_axi_arvalid && stat_stall_cycles != 32'hFFFF_FFFF) begin
      stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kvadd2_example_ar_issuer.sv
// tb/tb_kvadd2_example_ar_issuer.sv - self-checking bench for kvadd2_example_ar_issuer
module tb_kvadd2_example_ar_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_start;
  logic [63:0] ctrl_addr_offset;
  logic [31:0] ctrl_xfer_size_in_bytes;
  logic        ctrl_done;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic        rxfer_last;
`ifdef KVADD2_AR_ISSUER_STATS_EN
  logic [31:0] stat_stall_cycles;
`endif

  kvadd2_example_ar_issuer dut (
    .clk                     (clk),
    .rst                     (rst),
    .ctrl_start              (ctrl_start),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .ctrl_done               (ctrl_done),
`ifdef KVADD2_AR_ISSUER_STATS_EN
    .stat_stall_cycles       (stat_stall_cycles),
`endif
    .m_axi_arvalid           (m_axi_arvalid),
    .m_axi_arready           (m_axi_arready),
    .m_axi_araddr            (m_axi_araddr),
    .m_axi_arlen             (m_axi_arlen),
    .rxfer_last              (rxfer_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] size;
    logic [63:0] base;
    int          nb;
    logic [7:0]  last_len;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  vec_t vecs[8];
  ar_t  exp_q[$];
  ar_t  mon_e;
  int   due_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_count = 0;
  int done_count = 0;
  int first_hs_cyc = -1;
  int last_hs_cyc = -1;
  int done_cyc = -1;
  int last_rx_cyc = -1;
  bit rx_auto = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: score every AR handshake and log done pulses.
  always @(negedge clk) begin
    if (!rst && m_axi_arvalid && m_axi_arready) begin
      if (hs_count == 0) first_hs_cyc = cyc;
      hs_count++;
      last_hs_cyc = cyc;
      due_q.push_back(cyc + 3);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ar: got addr 0x%0h len %0d, expected no request", m_axi_araddr, m_axi_arlen);
      end else begin
        mon_e = exp_q.pop_front();
        chk("araddr", m_axi_araddr, mon_e.addr);
        chk("arlen", {56'd0, m_axi_arlen}, {56'd0, mon_e.len});
      end
    end
    if (ctrl_done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  // Read-data stand-in: retire each burst three cycles after its AR.
  always @(posedge clk) begin
    #1;
    if (rx_auto) begin
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        rxfer_last  = 1'b1;
        last_rx_cyc = cyc;
      end else begin
        rxfer_last = 1'b0;
      end
    end
  end

  task automatic push_bursts(input logic [63:0] base, input int nb, input logic [7:0] last_len);
    ar_t e;
    for (int i = 0; i < nb; i++) begin
      e.addr = base + 64'(i) * 64'd4096;
      e.len  = (i == nb - 1) ? last_len : 8'd63;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_xfer(input logic [63:0] addr, input logic [31:0] size, output int start_c);
    hs_count   = 0;
    done_count = 0;
    ctrl_addr_offset        = addr;
    ctrl_xfer_size_in_bytes = size;
    ctrl_start = 1'b1;
    start_c    = cyc;
    tick();
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_count == 0; k++) tick();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int start_c;
    push_bursts(v.base, v.nb, v.last_len);
    start_xfer(v.addr, v.size, start_c);
    wait_done(3000);
    chk({tag, "_done_seen"}, 64'(done_count), 64'd1);
    if (v.nb == 0) begin
      chk({tag, "_zero_done_cycle"}, 64'(done_cyc - start_c), 64'd2);
      chk({tag, "_zero_no_ar"}, 64'(hs_count), 64'd0);
    end else begin
      chk({tag, "_first_ar_cycle"}, 64'(first_hs_cyc - start_c), 64'd2);
      chk({tag, "_ar_count"}, 64'(hs_count), 64'(v.nb));
      chk({tag, "_done_latency"}, 64'(done_cyc - last_rx_cyc), 64'd2);
    end
    tick();
    tick();
    chk({tag, "_done_one_pulse"}, 64'(done_count), 64'd1);
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int start_c;
    int rx_c;
    logic [31:0] s0;
    vec_t rv;

    vecs[0] = '{64'h1000_0000, 32'd8192,  64'h1000_0000, 2, 8'd63};
    vecs[1] = '{64'h2000_0000, 32'd100,   64'h2000_0000, 1, 8'd1};
    vecs[2] = '{64'h3000_0000, 32'd0,     64'h3000_0000, 0, 8'd0};
    vecs[3] = '{64'h4000_0123, 32'd4097,  64'h4000_0000, 2, 8'd0};
    vecs[4] = '{64'h4100_0000, 32'd64,    64'h4100_0000, 1, 8'd0};
    vecs[5] = '{64'h4200_0000, 32'd4096,  64'h4200_0000, 1, 8'd63};
    vecs[6] = '{64'h4300_0000, 32'd12287, 64'h4300_0000, 3, 8'd63};
    vecs[7] = '{64'h4400_0000, 32'd21120, 64'h4400_0000, 6, 8'd9};

    rst = 1'b1;
    ctrl_start = 1'b0;
    ctrl_addr_offset = 64'd0;
    ctrl_xfer_size_in_bytes = 32'd0;
    m_axi_arready = 1'b1;
    rxfer_last = 1'b0;
    repeat (3) tick();
    chk("reset_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
    chk("reset_araddr", m_axi_araddr, 64'd0);
    chk("reset_arlen", {56'd0, m_axi_arlen}, 64'd0);
    chk("reset_done", {63'd0, ctrl_done}, 64'd0);
`ifdef KVADD2_AR_ISSUER_STATS_EN
    chk("reset_stat", {32'd0, stat_stall_cycles}, 64'd0);
`endif
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Outstanding cap: 20 bursts, no retirements until the stall is seen.
    rx_auto = 1'b0;
    push_bursts(64'h6000_0000, 20, 8'd63);
    start_xfer(64'h6000_0000, 32'd81920, start_c);
    for (int k = 0; k < 100 && hs_count < 16; k++) tick();
    repeat (5) tick();
    chk("cap_ar_count", 64'(hs_count), 64'd16);
    chk("cap_arvalid_low", {63'd0, m_axi_arvalid}, 64'd0);
`ifdef KVADD2_AR_ISSUER_STATS_EN
    s0 = stat_stall_cycles;
    tick();
    chk("cap_stat_incr", {32'd0, stat_stall_cycles}, {32'd0, s0 + 32'd1});
`else
    s0 = 32'd0;
`endif
    rxfer_last = 1'b1;
    void'(due_q.pop_front());
    rx_c = cyc;
    last_rx_cyc = cyc;
    tick();
    rxfer_last = 1'b0;
    tick();
    chk("cap_17th_ar_count", 64'(hs_count), 64'd17);
    chk("cap_17th_ar_cycle", 64'(last_hs_cyc - rx_c), 64'd1);
    chk("cap_arvalid_low_again", {63'd0, m_axi_arvalid}, 64'd0);
    rx_auto = 1'b1;
    wait_done(3000);
    chk("cap_total_ars", 64'(hs_count), 64'd20);
    chk("cap_done_seen", 64'(done_count), 64'd1);
    chk("cap_done_latency", 64'(done_cyc - last_rx_cyc), 64'd2);
    chk("cap_sb_empty", 64'(exp_q.size()), 64'd0);
    tick();

    // Backpressure: hold arready low for five ISSUE cycles, stray start ignored.
    m_axi_arready = 1'b0;
    push_bursts(64'h5000_0000, 3, 8'd63);
    start_xfer(64'h5000_0000, 32'd12288, start_c);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_arvalid_held", {63'd0, m_axi_arvalid}, 64'd1);
      chk("bp_araddr_stable", m_axi_araddr, 64'h5000_0000);
      chk("bp_arlen_stable", {56'd0, m_axi_arlen}, 64'd63);
      if (k == 2) begin
        ctrl_addr_offset = 64'h7000_0000;
        ctrl_xfer_size_in_bytes = 32'd4096;
        ctrl_start = 1'b1;
      end
      tick();
      ctrl_start = 1'b0;
    end
    m_axi_arready = 1'b1;
    wait_done(3000);
    chk("bp_ar_count", 64'(hs_count), 64'd3);
    chk("bp_done_seen", 64'(done_count), 64'd1);
    chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);
    tick();

    // Reset with three bursts outstanding, then a fresh single-burst transfer.
    rx_auto = 1'b0;
    push_bursts(64'h8000_0000, 10, 8'd63);
    start_xfer(64'h8000_0000, 32'd40960, start_c);
    for (int k = 0; k < 100 && hs_count < 3; k++) tick();
    m_axi_arready = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_mid_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
    chk("rst_mid_done", {63'd0, ctrl_done}, 64'd0);
    chk("rst_mid_araddr", m_axi_araddr, 64'd0);
    rst = 1'b0;
    exp_q.delete();
    due_q.delete();
    m_axi_arready = 1'b1;
    rx_auto = 1'b1;
    tick();
    rv = '{64'h9000_0000, 32'd4096, 64'h9000_0000, 1, 8'd63};
    run_vec(rv, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
